shift_load_controller: RTL and testbench
========================================

# shift_load_controller

Sequences a SERIAL_TO_PARALLEL shift register to load a full Conway board, one row at a time, from a serial bit stream. A valid/ready bit interface feeds the register. The block counts bits per row and presents each completed row on a valid/ready row-write interface, addressed by row index. It sits between the host serial input and the board row memory, and owns the single shift-register instance.

## Interface
Parameters:
- data_size, 64, bits per row (width of the owned shift register); must be ≥ 2
- num_rows, 64, rows per board; must be ≥ 1

Ports:
- CLK  in  1  system clock; all logic on posedge
- RST_N  in  1  reset; one clock, synchronous, active-low
- START  in  1  begin a board load; honoured only in IDLE
- ABORT  in  1  cancel the load from any state
- BIT_IN  in  1  serial data bit
- BIT_VALID  in  1  BIT_IN is valid
- BIT_READY  out  1  controller accepts a bit this cycle
- ROW_DATA  out  data_size  completed row, taken from the shift-register contents
- ROW_ADDR  out  $clog2(num_rows) (min 1)  row index of ROW_DATA
- ROW_VALID  out  1  ROW_DATA and ROW_ADDR are valid
- ROW_READY  in  1  row sink accepts the row
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse after the last row is accepted

## Operation
- States: IDLE, CLEAR, SHIFT, WRITE, FINISH.
- IDLE
  - All handshake outputs are low.
  - START && !ABORT → CLEAR; bit_cnt and row_cnt are zeroed.
- CLEAR
  - Lasts exactly one cycle, then → SHIFT unconditionally.
  - The dedicated flop sr_clr is high during this cycle only and drives the shift register's async active-high RST, so the clear is glitch-free.
  - sr_clr is also high while RST_N is low.
- SHIFT
  - BIT_READY = 1.
  - On accept (BIT_VALID && BIT_READY): the shift register's EN = 1 and DATA_IN = BIT_IN combinationally in the same cycle, and bit_cnt increments.
  - Accept with bit_cnt == data_size-1 → WRITE, with bit_cnt reset to 0.
- WRITE
  - ROW_VALID = 1, ROW_DATA = shift-register contents, ROW_ADDR = row_cnt.
  - ROW_DATA and ROW_ADDR are held stable until ROW_READY.
  - On ROW_READY: if row_cnt == num_rows-1 → FINISH, else row_cnt increments → SHIFT.
  - The shift register is not cleared between rows; each row fully overwrites it.
- FINISH
  - DONE = 1 for one cycle, then → IDLE.
- Bit order: the first bit accepted for a row lands in ROW_DATA[data_size-1] and the last in ROW_DATA[0].
- ABORT
  - Takes priority over every other condition in every state.
  - Next state is IDLE, counters are zeroed, and no DONE is issued.
  - A bit offered in the ABORT cycle is not accepted (BIT_READY is forced low).
  - A pending row is dropped (ROW_VALID is forced low).
- START outside IDLE is ignored.
- Counters never exceed their terminal values; there is no wrap except through the explicit reset paths above.

## Timing
- Reset values: BIT_READY = 0, ROW_VALID = 0, ROW_DATA = 0, ROW_ADDR = 0, BUSY = 0, DONE = 0; state = IDLE.
- START sampled in cycle t:
  - CLEAR in t+1.
  - BIT_READY first high in t+2.
- ROW_VALID rises the cycle after the row's last bit is accepted.
- Minimum cycles per row = data_size + 1 (bits plus the WRITE handshake).
- Minimum full-load time from START to DONE = 2 + num_rows·(data_size+1) cycles.
- RST_N low mid-operation:
  - The next edge forces reset values.
  - The shift register is cleared via sr_clr.
- ROW_READY asserted before ROW_VALID has no effect.

## Structure
- Shared package conway_pkg holds:
  - the state enum type (IDLE, CLEAR, SHIFT, WRITE, FINISH);
  - a width helper constant function for the counters.
- One sub-module: the SERIAL_TO_PARALLEL instance, with data_size passed through and RST driven by sr_clr.
- The controller itself is a single module with one state register, two counters and the sr_clr flop.

## Test plan
Bench parameters: data_size = 8, num_rows = 4.
- Reset then idle: hold RST_N low for 2 cycles, release → all outputs 0; BIT_VALID = 1 with no START → BIT_READY stays 0.
- Full load, streaming: START, then 32 bits with BIT_VALID always high and ROW_READY always high, rows 0xA5, 0x3C, 0xFF, 0x01 MSB-first → four ROW_VALID pulses at ROW_ADDR 0..3 with exactly those values; DONE 38 cycles after START.
- Backpressure: hold ROW_READY low for 5 cycles on row 1 → ROW_DATA = 0x3C and ROW_ADDR = 1 stay stable and BIT_READY = 0 throughout; the load then completes with correct data.
- Gapped input: toggle BIT_VALID every cycle → only accepted bits count; row values match the streaming case.
- Abort: assert ABORT after 5 bits of row 2 → IDLE next cycle, BUSY = 0, no DONE. A new START then loads from row 0 with no residue from the aborted row.
- Reset mid-row: RST_N low for 1 cycle during SHIFT → reset values. A following load of 0x80 on row 0 produces exactly 0x80.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and helpers for the Conway board loader.
package conway_pkg;

  // Controller states, exposed on state_dbg for observation.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Width of a counter that spans 0..n-1; at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Serial-in, parallel-out shift register. The first bit shifted in ends up
// in the MSB after data_size shifts. RST is an asynchronous active-high clear
// driven from a dedicated flop, so it is glitch-free.
module serial_to_parallel #(
  parameter int data_size = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 DATA_IN,
  output logic [data_size-1:0] DATA_OUT
);

  // Shift left by one on each enabled clock; clear asynchronously on RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_OUT <= '0;
    end else if (EN) begin
      DATA_OUT <= {DATA_OUT[data_size-2:0], DATA_IN};
    end
  end

endmodule

// File: rtl/shift_load_controller.sv
// Loads a full Conway board row by row from a serial bit stream.
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high at the rising clock edge. BIT_READY/BIT_VALID move one serial bit,
// ROW_VALID/ROW_READY move one completed row. A source holds its data
// stable while valid is high and ready is low. ABORT forces both ready and
// valid outputs low in the cycle it is asserted.
module shift_load_controller
  import conway_pkg::*;
#(
  parameter  int data_size = 64,
  parameter  int num_rows  = 64,
  localparam int bw        = cnt_width(data_size),
  localparam int aw        = cnt_width(num_rows)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 BIT_IN,
  input  logic                 BIT_VALID,
  output logic                 BIT_READY,
  output logic [data_size-1:0] ROW_DATA,
  output logic [aw-1:0]        ROW_ADDR,
  output logic                 ROW_VALID,
  input  logic                 ROW_READY,
  output logic                 BUSY,
  output logic                 DONE,
  output state_t               state_dbg
);

  localparam logic [bw-1:0] bit_last = bw'(data_size - 1);
  localparam logic [aw-1:0] row_last = aw'(num_rows - 1);

  state_t        state;
  logic [bw-1:0] bit_cnt;
  logic [aw-1:0] row_cnt;
  logic          sr_clr;
  logic          sr_en;

  // Handshake outputs decode the state; ABORT masks them in its own cycle
  // so no bit is taken and no row is offered while cancelling.
  assign BIT_READY = (state == SHIFT) && !ABORT;
  assign ROW_VALID = (state == WRITE) && !ABORT;
  assign DONE      = (state == FINISH) && !ABORT;
  assign BUSY      = (state != IDLE);
  assign ROW_ADDR  = row_cnt;
  assign sr_en     = BIT_READY && BIT_VALID;
  assign state_dbg = state;

  // The single shift register; it is only cleared at load start or reset,
  // since each row fully overwrites it.
  serial_to_parallel #(
    .data_size(data_size)
  ) u_sr (
    .CLK     (CLK),
    .RST     (sr_clr),
    .EN      (sr_en),
    .DATA_IN (BIT_IN),
    .DATA_OUT(ROW_DATA)
  );

  // Controller state, counters and the shift-register clear flop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      bit_cnt <= '0;
      row_cnt <= '0;
      sr_clr  <= 1'b1;
    end else begin
      sr_clr <= 1'b0;
      if (ABORT) begin
        state   <= IDLE;
        bit_cnt <= '0;
        row_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              state   <= CLEAR;
              sr_clr  <= 1'b1;
              bit_cnt <= '0;
              row_cnt <= '0;
            end
          end
          CLEAR: begin
            state <= SHIFT;
          end
          SHIFT: begin
            if (BIT_VALID) begin
              if (bit_cnt == bit_last) begin
                bit_cnt <= '0;
                state   <= WRITE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          WRITE: begin
            if (ROW_READY) begin
              if (row_cnt == row_last) begin
                state <= FINISH;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                state   <= SHIFT;
              end
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_load_controller.sv
// Bench for shift_load_controller with data_size = 8, num_rows = 4.
module tb_shift_load_controller;
  import conway_pkg::*;

  localparam int data_size = 8;
  localparam int num_rows  = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       BIT_IN = 1'b0;
  logic       BIT_VALID = 1'b0;
  logic       ROW_READY = 1'b0;
  logic       BIT_READY;
  logic       ROW_VALID;
  logic       BUSY;
  logic       DONE;
  logic [7:0] ROW_DATA;
  logic [1:0] ROW_ADDR;
  state_t     state_dbg;

  int errors = 0;
  int checks = 0;

  // Expected rows as {addr, data}, in delivery order.
  logic [9:0] exp_q[$];

  // Clock and DUT.
  always #5 CLK = ~CLK;

  shift_load_controller #(
    .data_size(data_size),
    .num_rows (num_rows)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .ABORT    (ABORT),
    .BIT_IN   (BIT_IN),
    .BIT_VALID(BIT_VALID),
    .BIT_READY(BIT_READY),
    .ROW_DATA (ROW_DATA),
    .ROW_ADDR (ROW_ADDR),
    .ROW_VALID(ROW_VALID),
    .ROW_READY(ROW_READY),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bit_ready"}, BIT_READY, 0);
    check({tag, "_row_valid"}, ROW_VALID, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
  endtask

  // A few idle cycles with a bit offered and no START: nothing happens.
  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      BIT_VALID = 1'b1;
      BIT_IN    = 1'($urandom_range(0, 1));
      ROW_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check_idle(tag);
      @(posedge CLK); #1;
    end
    BIT_VALID = 1'b0;
  endtask

  // One board load. The reference is the row values themselves: the stream
  // is their MSB-first serialisation, and each row must come back intact at
  // its index. vmode: 0 always valid, 1 alternate, 2 random. rmode: 0 always
  // ready, 1 random. bp_row/bp_len: hold ROW_READY low on that row.
  // abort_at/rst_at: bit count at which ABORT or RST_N low is applied.
  task automatic run_load(input logic [7:0] rows [4], input int vmode, input int rmode,
                          input int bp_row, input int bp_len, input int abort_at,
                          input int rst_at, input int exp_done_cyc);
    int b;
    int cyc;
    int bp_left;
    bit stop;
    bit bp_active;
    logic [9:0] head;
    b = 0; bp_left = bp_len; stop = 1'b0;
    exp_q.delete();
    for (int r = 0; r < num_rows; r++) exp_q.push_back({2'(r), rows[r]});

    START = 1'b1; BIT_VALID = 1'b0; ROW_READY = 1'b0; ABORT = 1'b0;
    @(negedge CLK);
    check("start_busy_before", BUSY, 0);
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check("clear_state", 32'(state_dbg), 32'(CLEAR));
    check("clear_bit_ready", BIT_READY, 0);
    check("clear_busy", BUSY, 1);
    @(posedge CLK); #1;
    cyc = 2;

    while (!stop && cyc < 400) begin
      ABORT = (abort_at >= 0 && b == abort_at);
      if (rst_at >= 0 && b == rst_at) RST_N = 1'b0;
      case (vmode)
        0:       BIT_VALID = 1'b1;
        1:       BIT_VALID = cyc[0];
        default: BIT_VALID = 1'($urandom_range(0, 1));
      endcase
      if (BIT_VALID && b < data_size * num_rows)
        BIT_IN = rows[b / data_size][data_size - 1 - (b % data_size)];
      else
        BIT_IN = 1'($urandom_range(0, 1));
      ROW_READY = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bp_active = 1'b0;
      if (ROW_VALID && int'(ROW_ADDR) == bp_row && bp_left > 0) begin
        ROW_READY = 1'b0;
        bp_left--;
        bp_active = 1'b1;
      end

      @(negedge CLK);
      if (!RST_N) begin
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check_idle("rst_mid");
        check("rst_mid_row_data", ROW_DATA, 0);
        check("rst_mid_row_addr", ROW_ADDR, 0);
        @(posedge CLK); #1;
        stop = 1'b1;
      end else if (ABORT) begin
        check("abort_bit_ready", BIT_READY, 0);
        check("abort_row_valid", ROW_VALID, 0);
        check("abort_done", DONE, 0);
        @(posedge CLK); #1;
        ABORT = 1'b0;
        @(negedge CLK);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check_idle("abort_after");
        @(posedge CLK); #1;
        stop = 1'b1;
      end else begin
        if (bp_active) check("bp_bit_ready", BIT_READY, 0);
        if (ROW_VALID) begin
          check("row_valid_no_bit_ready", BIT_READY, 0);
          if (exp_q.size() == 0) begin
            check("row_unexpected", 1, 0);
          end else begin
            head = exp_q[0];
            check("row_addr", ROW_ADDR, head[9:8]);
            check("row_data", ROW_DATA, head[7:0]);
            if (ROW_READY) void'(exp_q.pop_front());
          end
        end
        if (BIT_VALID && BIT_READY) b++;
        if (DONE) begin
          if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
          check("done_rows_left", exp_q.size(), 0);
          check("done_bits", b, data_size * num_rows);
          @(posedge CLK); #1;
          @(negedge CLK);
          check_idle("after_done");
          @(posedge CLK); #1;
          stop = 1'b1;
        end else begin
          @(posedge CLK); #1;
          cyc++;
        end
      end
    end
    if (!stop) check("load_timeout", 1, 0);
    BIT_VALID = 1'b0; ROW_READY = 1'b0; ABORT = 1'b0;
  endtask

  logic [7:0] pat [4];
  logic [7:0] rnd [4];

  initial begin
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h01;

    // Reset then idle.
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check_idle("reset");
    check("reset_row_data", ROW_DATA, 0);
    check("reset_row_addr", ROW_ADDR, 0);
    @(posedge CLK); #1;
    idle_cycles(3, "no_start");

    // Streaming load with exact timing.
    run_load(pat, 0, 0, -1, 0, -1, -1, 38);
    // Row 1 backpressured for 5 cycles.
    run_load(pat, 0, 0, 1, 5, -1, -1, 43);
    // Gapped input.
    run_load(pat, 1, 0, -1, 0, -1, -1, -1);

    // Abort 5 bits into row 2, then a clean reload.
    run_load(pat, 0, 0, -1, 0, 2 * data_size + 5, -1, -1);
    idle_cycles(3, "post_abort");
    for (int r = 0; r < num_rows; r++) rnd[r] = 8'($urandom);
    run_load(rnd, 0, 0, -1, 0, -1, -1, 38);

    // Reset mid-row, then a load whose first row is 0x80.
    run_load(pat, 0, 0, -1, 0, -1, 3, -1);
    rnd[0] = 8'h80;
    for (int r = 1; r < num_rows; r++) rnd[r] = 8'($urandom);
    run_load(rnd, 0, 0, -1, 0, -1, -1, 38);

    // Random rows, random valid and ready.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < num_rows; r++) rnd[r] = 8'($urandom);
      run_load(rnd, 2, 1, -1, 0, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
